gfx_pattern_gen_striped: RTL and testbench
==========================================

// Module: gfx_pattern_gen_striped
// PURPOSE
// - Parametrised frame-buffer pattern writer. Walks a V_VISIBLE x H_VISIBLE frame
//   and emits one pixel write per beat on a valid/ready stream.
// - Each beat carries x/y, a stripe bank index and an in-bank address, so a striped
//   SRAM writer with NUM_S banks can consume it directly.
// - Four selectable patterns; single-frame or continuous operation.
// PARAMETERS
// - NUM_S        2    stripe bank count; power of 2, >=1; H_VISIBLE % NUM_S == 0
// - COLOR_WIDTH  4    bits per colour channel; pixel = {red,grn,blu}
// - H_VISIBLE    800  pixels per line
// - V_VISIBLE    600  lines per frame
// - ADDR_WIDTH   20   in-bank address width; >= clog2(H_VISIBLE*V_VISIBLE/NUM_S)
// - BAR_SHIFT    7    colour-bar width is 2**BAR_SHIFT pixels
// - CHECK_SHIFT  5    checker square size is 2**CHECK_SHIFT pixels
// PORTS
// - clk             in   1                clock
// - rst_n           in   1                synchronous active-low reset
// - start           in   1                begin a frame (sampled in IDLE only)
// - continuous      in   1                1: restart after each frame
// - mode            in   2                0 bars, 1 checker, 2 gradient, 3 solid
// - fill_pixel      in   3*COLOR_WIDTH    solid-mode colour
// - busy            out  1                high in RUN
// - done            out  1                one-cycle pulse at end of the last frame
// - frame_cnt       out  16               completed frames; wraps
// - m_gfx_valid     out  1                pixel beat valid
// - m_gfx_ready     in   1                consumer accepts the beat
// - m_gfx_x         out  clog2(H_VISIBLE) pixel column
// - m_gfx_y         out  clog2(V_VISIBLE) pixel row
// - m_gfx_bank      out  max(1,clog2(NUM_S)) stripe bank = x mod NUM_S
// - m_gfx_addr      out  ADDR_WIDTH       in-bank address = (y*H_VISIBLE+x)/NUM_S
// - m_gfx_pixel     out  3*COLOR_WIDTH    pixel colour
// BEHAVIOUR
// - Reset: state IDLE. busy=0, done=0, m_gfx_valid=0, frame_cnt=0.
//   x=y=bank=addr=0, pixel=0. A reset mid-frame aborts the frame immediately.
// - FSM: IDLE -> RUN on start. RUN -> RUN on the last beat when continuous=1.
//   RUN -> DONE on the last beat when continuous=0. DONE -> IDLE unconditionally.
// - Latency: start high in cycle N -> m_gfx_valid=1 with x=0, y=0 in cycle N+1.
// - mode and fill_pixel are latched at each frame start and stay stable for the frame.
// - Handshake: a beat transfers when valid&&ready. While valid&&!ready, every m_gfx_*
//   output holds. Valid stays high for the whole frame, including back-to-back frames.
//   At full rate the block issues one beat per cycle. valid never depends on ready.
// - Scan: x increments first; at x=H_VISIBLE-1 it wraps to 0 and y increments.
// - Last beat is x=H_VISIBLE-1, y=V_VISIBLE-1. When it is accepted, frame_cnt
//   increments in the same cycle.
// - Back-to-back frames: continuous is sampled on the last beat. If 1, the next
//   cycle presents x=0, y=0 with valid=1 and the newly latched mode.
// - bank/addr: bank = x[log2 NUM_S-1:0]. addr is a running counter that increments
//   on each accepted beat where bank==NUM_S-1, and clears at frame start.
// - Patterns (colour is registered together with the coordinates). xs is x or x+frame.
//   - 0 bars: b = xs>>BAR_SHIFT. red={CW{b[2]}}, grn={CW{b[1]}}, blu={CW{b[0]}}.
//   - 1 checker: all-ones if (xs[CHECK_SHIFT]^y[CHECK_SHIFT]), else 0.
//   - 2 gradient: red = xs[CW-1:0], grn = y[CW-1:0], blu = 0 or frame.
//   - 3 solid: fill_pixel.
// - done pulses for exactly 1 cycle (the DONE state). busy=0 in IDLE and DONE.
// - start while busy is ignored.
// CONFIGURATION
// - GFX_PATTERN_ANIM_EN defined:
//   - xs = (x + frame_cnt) mod 2**width(x), so patterns scroll one pixel per frame.
//   - Gradient blu = frame_cnt[CW-1:0].
// - GFX_PATTERN_ANIM_EN undefined: xs = x and gradient blu = 0. frame_cnt still counts.
// TESTING (bench params: NUM_S=2, CW=4, H=8, V=4, BAR_SHIFT=0, CHECK_SHIFT=1)
// - Reset, then start=1 mode=3 fill=12'hABC continuous=0, ready=1:
//   - 32 beats, all pixel=ABC.
//   - Last beat is x=7, y=3, bank=1, addr=15.
//   - done pulses 1 cycle; frame_cnt=1.
// - Mode 0, ready=1: beat x=5, y=0 -> pixel=12'h0F0F (b=5 -> red=F, grn=0, blu=F);
//   beat x=6 -> 12'hFF0.
// - Mode 1: (x=2,y=0) -> FFF; (x=2,y=2) -> 000; (x=0,y=0) -> 000.
// - Random ready stalls (~50%):
//   - All outputs stable while stalled.
//   - Beats arrive in raster order, none lost or duplicated; addr sequence is
//     0,0,1,1,...,15,15.
// - continuous=1 for 3 frames, then drop it:
//   - No valid gap at frame boundaries; frame_cnt 1,2,3.
//   - Stops after the frame in which continuous=0 is sampled; done pulses once.
// - Assert rst_n=0 at beat 10 for 1 cycle: next cycle valid=0, busy=0, frame_cnt=0.
//   Re-start resumes at x=0, y=0.
// - With GFX_PATTERN_ANIM_EN, mode 2: frame 1 beat (x=0,y=0) -> red=1, blu=1.
//   Without the macro -> red=0, blu=0.

Source files
------------

// File: rtl/gfx_pattern_gen_striped.sv
// Frame-buffer pattern writer: raster-scans H_VISIBLE x V_VISIBLE, one pixel beat per accepted cycle,
// tagged with stripe bank and in-bank address. Define GFX_PATTERN_ANIM_EN to scroll patterns per frame.
module gfx_pattern_gen_striped #(
    parameter int NUM_S       = 2,
    parameter int COLOR_WIDTH = 4,
    parameter int H_VISIBLE   = 800,
    parameter int V_VISIBLE   = 600,
    parameter int ADDR_WIDTH  = 20,
    parameter int BAR_SHIFT   = 7,
    parameter int CHECK_SHIFT = 5
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                start,
    input  logic                                                continuous,
    input  logic [1:0]                                          mode,
    input  logic [3*COLOR_WIDTH-1:0]                            fill_pixel,
    output logic                                                busy,
    output logic                                                done,
    output logic [15:0]                                         frame_cnt,
    output logic                                                m_gfx_valid,
    input  logic                                                m_gfx_ready,
    output logic [((H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1)-1:0] m_gfx_x,
    output logic [((V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1)-1:0] m_gfx_y,
    output logic [((NUM_S > 1) ? $clog2(NUM_S) : 1)-1:0]         m_gfx_bank,
    output logic [ADDR_WIDTH-1:0]                               m_gfx_addr,
    output logic [3*COLOR_WIDTH-1:0]                            m_gfx_pixel
);
    localparam int XW = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int YW = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int BW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int CW = COLOR_WIDTH;
    localparam int PW = 3 * COLOR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XW-1:0] X_LAST    = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_VISIBLE - 1);
    localparam logic [BW-1:0] BANK_LAST = BW'(NUM_S - 1);

    logic [1:0]            state;
    logic [XW-1:0]         x, nx, xs;
    logic [YW-1:0]         y, ny;
    logic [ADDR_WIDTH-1:0] addr;
    logic [PW-1:0]         pixel, pix_nxt, fill_q, nfill;
    logic [1:0]            mode_q, nmode;
    logic [15:0]           nfrm;
    logic [CW-1:0]         gblu;
    logic                  acc, last, load, adv;

    // Bit k of a coordinate, reading as 0 beyond its width (shift avoids out-of-range selects).
    function automatic logic xbit(input logic [XW-1:0] v, input int k);
        logic [XW-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic logic ybit(input logic [YW-1:0] v, input int k);
        logic [YW-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    generate
        if (NUM_S > 1) begin : g_bank
            assign m_gfx_bank = x[BW-1:0];
        end else begin : g_nobank
            assign m_gfx_bank = '0;
        end
    endgenerate

    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign m_gfx_valid = (state == S_RUN);
    assign m_gfx_x     = x;
    assign m_gfx_y     = y;
    assign m_gfx_addr  = addr;
    assign m_gfx_pixel = pixel;

    always_comb begin
        acc   = (state == S_RUN) && m_gfx_ready;
        last  = acc && (x == X_LAST) && (y == Y_LAST);
        load  = ((state == S_IDLE) && start) || (last && continuous);
        adv   = acc && !last;
        nfrm  = last ? frame_cnt + 16'd1 : frame_cnt;
        nx    = x;
        ny    = y;
        nmode = mode_q;
        nfill = fill_q;
        if (load) begin
            nx    = '0;
            ny    = '0;
            nmode = mode;
            nfill = fill_pixel;
        end else if (adv) begin
            if (x == X_LAST) begin
                nx = '0;
                ny = y + 1'b1;
            end else begin
                nx = x + 1'b1;
            end
        end
    end

    // Colour is computed from the next coordinates and the frame count of the frame they belong to.
    always_comb begin
`ifdef GFX_PATTERN_ANIM_EN
        xs   = nx + nfrm[XW-1:0];
        gblu = nfrm[CW-1:0];
`else
        xs   = nx;
        gblu = '0;
`endif
        pix_nxt = '0;
        case (nmode)
            2'd0: pix_nxt = {{CW{xbit(xs, BAR_SHIFT + 2)}},
                             {CW{xbit(xs, BAR_SHIFT + 1)}},
                             {CW{xbit(xs, BAR_SHIFT)}}};
            2'd1: pix_nxt = (xbit(xs, CHECK_SHIFT) ^ ybit(ny, CHECK_SHIFT)) ? '1 : '0;
            2'd2: begin
                for (int i = 0; i < CW; i++) begin
                    pix_nxt[2*CW+i] = xbit(xs, i);
                    pix_nxt[CW+i]   = ybit(ny, i);
                    pix_nxt[i]      = gblu[i];
                end
            end
            default: pix_nxt = nfill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            pixel     <= '0;
            mode_q    <= '0;
            fill_q    <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (last) state <= continuous ? S_RUN : S_DONE;
                default: state <= S_IDLE;
            endcase
            x         <= nx;
            y         <= ny;
            mode_q    <= nmode;
            fill_q    <= nfill;
            frame_cnt <= nfrm;
            if (load)
                addr <= '0;
            else if (adv && (m_gfx_bank == BANK_LAST))
                addr <= addr + 1'b1;
            if (load || adv)
                pixel <= pix_nxt;
        end
    end
endmodule

// File: tb/tb_gfx_pattern_gen_striped.sv
// Bench for gfx_pattern_gen_striped: scoreboard of expected beats plus a table of per-frame pixel probes.
module tb_gfx_pattern_gen_striped;
    localparam int CW = 4, H = 8, V = 4, AW = 8;
`ifdef GFX_PATTERN_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  x;
        logic [1:0]  y;
        logic        bank;
        logic [7:0]  addr;
        logic [11:0] pixel;
    } beat_t;

    typedef struct {
        logic [1:0]  md;
        logic [11:0] fl;
        int          px;
        int          py;
        logic [11:0] exp_pix;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] fill_pixel = 12'h000;
    logic        busy, done;
    logic [15:0] frame_cnt;
    logic        m_gfx_valid;
    logic        m_gfx_ready = 1'b1;
    logic [2:0]  m_gfx_x;
    logic [1:0]  m_gfx_y;
    logic [0:0]  m_gfx_bank;
    logic [AW-1:0] m_gfx_addr;
    logic [11:0] m_gfx_pixel;

    int    checks = 0;
    int    failures = 0;
    int    done_seen = 0;
    int    beats_seen = 0;
    int    model_cnt = 0;
    bit    mon_en = 1'b0;
    bit    rand_rdy = 1'b0;
    bit    stalled = 1'b0;
    beat_t held, lastb;
    beat_t exp_q[$];
    logic [11:0] cap [0:V-1][0:H-1];

    gfx_pattern_gen_striped #(
        .NUM_S(2), .COLOR_WIDTH(CW), .H_VISIBLE(H), .V_VISIBLE(V),
        .ADDR_WIDTH(AW), .BAR_SHIFT(0), .CHECK_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .mode(mode), .fill_pixel(fill_pixel), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .m_gfx_valid(m_gfx_valid), .m_gfx_ready(m_gfx_ready),
        .m_gfx_x(m_gfx_x), .m_gfx_y(m_gfx_y), .m_gfx_bank(m_gfx_bank),
        .m_gfx_addr(m_gfx_addr), .m_gfx_pixel(m_gfx_pixel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_pix(input logic [1:0] md, input logic [11:0] fl,
                                              input int x, input int y, input int frm);
        int xs;
        logic [3:0] r, g, b;
        xs = ANIM ? (x + frm) % H : x;
        case (md)
            2'd0: begin r = {4{xs[2]}}; g = {4{xs[1]}}; b = {4{xs[0]}}; end
            2'd1: begin r = (xs[1] ^ y[1]) ? 4'hF : 4'h0; g = r; b = r; end
            2'd2: begin r = xs[3:0]; g = y[3:0]; b = ANIM ? frm[3:0] : 4'h0; end
            default: return fl;
        endcase
        return {r, g, b};
    endfunction

    task automatic push_frame(input logic [1:0] md, input logic [11:0] fl, input int frm);
        beat_t b;
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++) begin
                b.x = 3'(xx);
                b.y = 2'(yy);
                b.bank = 1'(xx % 2);
                b.addr = 8'((yy * H + xx) / 2);
                b.pixel = model_pix(md, fl, xx, yy, frm);
                exp_q.push_back(b);
            end
    endtask

    // Ready is chosen first, then the beat is judged against the ready that the next edge will see.
    always @(negedge clk) begin
        beat_t cur, e;
        cur = {m_gfx_x, m_gfx_y, m_gfx_bank, m_gfx_addr, m_gfx_pixel};
        if (done) done_seen++;
        if (!mon_en) begin
            stalled = 1'b0;
            m_gfx_ready = 1'b1;
        end else begin
            if (stalled) begin
                chk("stall_hold", 32'(cur), 32'(held));
                chk("stall_valid", 32'(m_gfx_valid), 32'd1);
            end
            m_gfx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_gfx_valid && m_gfx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected actual=%h expected=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'(cur), 32'(e));
                end
                cap[m_gfx_y][m_gfx_x] = m_gfx_pixel;
                lastb = cur;
                beats_seen++;
            end
            stalled = m_gfx_valid && !m_gfx_ready;
            held = cur;
        end
    end

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done expected=done within 2000 cycles");
        end
    endtask

    task automatic run_frame(input logic [1:0] md, input logic [11:0] fl);
        int d0;
        d0 = done_seen;
        push_frame(md, fl, model_cnt);
        mode = md;
        fill_pixel = fl;
        continuous = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("latency_valid", 32'(m_gfx_valid), 32'd1);
        chk("busy_run", 32'(busy), 32'd1);
        wait_done();
        model_cnt++;
        chk("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
        chk("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_pulses", 32'(done_seen - d0), 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t tbl[7];
        int   m, d0, b0, vc, cyc, fi;
        logic [15:0] lastfc;

        tbl[0] = '{2'd2, 12'h000, 0, 0, ANIM ? 12'h101 : 12'h000};
        tbl[1] = '{2'd0, 12'h000, 5, 0, ANIM ? 12'hFFF : 12'hF0F};
        tbl[2] = '{2'd0, 12'h000, 6, 0, ANIM ? 12'h00F : 12'hFF0};
        tbl[3] = '{2'd1, 12'h000, 2, 0, 12'hFFF};
        tbl[4] = '{2'd1, 12'h000, 2, 2, 12'h000};
        tbl[5] = '{2'd1, 12'h000, 0, 0, ANIM ? 12'hFFF : 12'h000};
        tbl[6] = '{2'd3, 12'h5A3, 4, 1, 12'h5A3};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(m_gfx_valid), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_coords", 32'({m_gfx_x, m_gfx_y, m_gfx_bank, m_gfx_addr}), 32'd0);
        chk("rst_pixel", 32'(m_gfx_pixel), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Solid frame; last beat must land on the final bank/address.
        run_frame(2'd3, 12'hABC);
        chk("last_beat", 32'(lastb), 32'({3'd7, 2'd3, 1'b1, 8'd15, 12'hABC}));

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].md, tbl[i].fl);
            chk($sformatf("probe%0d", i), 32'(cap[tbl[i].py][tbl[i].px]), 32'(tbl[i].exp_pix));
        end

        // Random stalls: scoreboard covers order, loss, duplication and address sequence.
        rand_rdy = 1'b1;
        run_frame(2'd2, 12'h000);
        rand_rdy = 1'b0;
        @(negedge clk);

        // Three back-to-back frames, continuous dropped during the third.
        d0 = done_seen;
        m = model_cnt;
        for (int f = 0; f < 3; f++) push_frame(2'd0, 12'h000, m + f);
        mode = 2'd0;
        continuous = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vc = m_gfx_valid ? 1 : 0;
        cyc = 0;
        fi = 0;
        lastfc = frame_cnt;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (frame_cnt != lastfc) begin
                chk("cont_frame_cnt", 32'(frame_cnt), 32'(m + 1 + fi));
                fi++;
                lastfc = frame_cnt;
            end
            if (done) break;
            if (m_gfx_valid) vc++;
            if (frame_cnt == 16'(m + 2)) continuous = 1'b0;
        end
        chk("cont_finished", 32'(done), 32'd1);
        chk("cont_valid_cycles", 32'(vc), 32'd96);
        chk("cont_frames", 32'(fi), 32'd3);
        model_cnt = m + 3;
        repeat (2) @(negedge clk);
        chk("cont_done_pulses", 32'(done_seen - d0), 32'd1);
        chk("cont_beats_left", 32'(exp_q.size()), 32'd0);

        // Synchronous reset mid-frame.
        push_frame(2'd3, 12'h0F0, model_cnt);
        mode = 2'd3;
        fill_pixel = 12'h0F0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b0 = beats_seen;
        cyc = 0;
        while (beats_seen < b0 + 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reset_reached_beat10", 32'(beats_seen >= b0 + 10), 32'd1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        chk("midrst_valid", 32'(m_gfx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        chk("midrst_idle", 32'(m_gfx_valid), 32'd0);
        mon_en = 1'b1;
        model_cnt = 0;
        run_frame(2'd1, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
